// File: rtl/cic_integrator_decimator.sv
// cic_integrator_decimator: N cascaded integrators with R:1 down-sampling; optional phase sync via CIC_INTEG_PHASE_SYNC_EN
module cic_integrator_decimator #(
  parameter int N = 3,
  parameter int R = 4,
  parameter int D = 1,
  parameter int PRECISION = 12,
  localparam int OUT_WIDTH = PRECISION + N * $clog2(R * D),
  localparam int PW = $clog2(R)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [PRECISION-1:0] x,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] y,
  output logic        [PW-1:0]        phase
`ifdef CIC_INTEG_PHASE_SYNC_EN
  ,
  input  logic                        sync
`endif
);
  logic signed [OUT_WIDTH-1:0] integ [N];
  logic signed [OUT_WIDTH-1:0] sum [N];
  logic signed [OUT_WIDTH-1:0] xe;
  logic last, s;
`ifdef CIC_INTEG_PHASE_SYNC_EN
  assign s = sync;
`else
  assign s = 1'b0;
`endif
  assign xe = {{(OUT_WIDTH - PRECISION){x[PRECISION-1]}}, x};
  assign last = phase == PW'(R - 1);
  // each stage adds the registered value of its predecessor, so the chain is fully pipelined
  always_comb begin
    sum[0] = integ[0] + xe;
    for (int k = 1; k < N; k++) sum[k] = integ[k] + integ[k-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ <= '{default: '0};
      phase <= '0;
      y <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid && last && !s;
      phase <= s ? '0 : in_valid ? (last ? '0 : phase + 1'b1) : phase;
      if (in_valid) integ <= sum;
      if (in_valid && last && !s) y <= sum[N-1];
    end
  end
endmodule

// File: tb/tb_cic_integrator_decimator.sv
// tb_cic_integrator_decimator: directed table plus gap, wrap, reset and sync sequences at N=3, R=4, D=1
module tb_cic_integrator_decimator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [11:0] x = '0;
  logic out_valid;
  logic signed [17:0] y;
  logic [1:0] phase;
`ifdef CIC_INTEG_PHASE_SYNC_EN
  logic sync = 1'b0;
`endif
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic v;
    logic signed [11:0] x;
    logic ov;
    logic [17:0] y;
    logic [1:0] ph;
  } vec_t;

  vec_t tbl [17];
  logic [17:0] imp [3];

  always #5 clk = ~clk;

  cic_integrator_decimator #(.N(3), .R(4), .D(1), .PRECISION(12)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .x(x),
    .out_valid(out_valid),
    .y(y),
    .phase(phase)
`ifdef CIC_INTEG_PHASE_SYNC_EN
    ,
    .sync(sync)
`endif
  );

  task automatic chk(input string nm, input logic ov, input logic [17:0] ey, input logic [1:0] ep);
    checks++;
    if (out_valid !== ov || y !== ey || phase !== ep) begin
      failures++;
      $display("FAIL %s: got out_valid=%0b y=%h phase=%0d, want out_valid=%0b y=%h phase=%0d",
               nm, out_valid, y, phase, ov, ey, ep);
    end
  endtask

  task automatic step(input logic v, input logic signed [11:0] xv);
    in_valid = v;
    x = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    x = '0;
    rst = 1'b1;
    #2;
    chk("reset", 1'b0, 18'd0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [17:0] m1, m2, m3, xe, ylast;
    logic [17:0] d1, d2, d3, c1, c2, c3;
    logic [17:0] ey;
    int gap;
    tbl[0]  = '{1'b1, 12'sd1, 1'b0, 18'd0,  2'd1};
    tbl[1]  = '{1'b1, 12'sd0, 1'b0, 18'd0,  2'd2};
    tbl[2]  = '{1'b0, 12'sd0, 1'b0, 18'd0,  2'd2};
    tbl[3]  = '{1'b1, 12'sd0, 1'b0, 18'd0,  2'd3};
    tbl[4]  = '{1'b1, 12'sd0, 1'b1, 18'd3,  2'd0};
    tbl[5]  = '{1'b0, 12'sd0, 1'b0, 18'd3,  2'd0};
    tbl[6]  = '{1'b0, 12'sd0, 1'b0, 18'd3,  2'd0};
    tbl[7]  = '{1'b1, 12'sd0, 1'b0, 18'd3,  2'd1};
    tbl[8]  = '{1'b1, 12'sd0, 1'b0, 18'd3,  2'd2};
    tbl[9]  = '{1'b1, 12'sd0, 1'b0, 18'd3,  2'd3};
    tbl[10] = '{1'b1, 12'sd0, 1'b1, 18'd21, 2'd0};
    tbl[11] = '{1'b1, 12'sd0, 1'b0, 18'd21, 2'd1};
    tbl[12] = '{1'b0, 12'sd0, 1'b0, 18'd21, 2'd1};
    tbl[13] = '{1'b1, 12'sd0, 1'b0, 18'd21, 2'd2};
    tbl[14] = '{1'b1, 12'sd0, 1'b0, 18'd21, 2'd3};
    tbl[15] = '{1'b1, 12'sd0, 1'b1, 18'd55, 2'd0};
    tbl[16] = '{1'b1, 12'sd0, 1'b0, 18'd55, 2'd1};
    imp[0] = 18'd3;
    imp[1] = 18'd21;
    imp[2] = 18'd55;

    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].x);
      chk($sformatf("impulse_vec%0d", i), tbl[i].ov, tbl[i].y, tbl[i].ph);
    end

    do_reset();
    ey = '0;
    for (int s = 0; s < 12; s++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 12'sd0);
        chk("gap_idle", 1'b0, ey, 2'(s % 4));
      end
      step(1'b1, s == 0 ? 12'sd1 : 12'sd0);
      if (s % 4 == 3) begin
        ey = imp[s / 4];
        chk("gap_strobe", 1'b1, ey, 2'd0);
      end else begin
        chk("gap_accept", 1'b0, ey, 2'((s + 1) % 4));
      end
    end

    do_reset();
    m1 = '0; m2 = '0; m3 = '0; ylast = '0;
    d1 = '0; d2 = '0; d3 = '0; c1 = '0; c2 = '0; c3 = '0;
    xe = 18'h3F800;
    for (int s = 0; s < 200; s++) begin
      step(1'b1, 12'sh800);
      m3 = m3 + m2;
      m2 = m2 + m1;
      m1 = m1 + xe;
      if (s % 4 == 3) begin
        ylast = m3;
        chk("wrap_strobe", 1'b1, ylast, 2'd0);
        c1 = y - d1; d1 = y;
        c2 = c1 - d2; d2 = c1;
        c3 = c2 - d3; d3 = c2;
      end else begin
        chk("wrap_hold", 1'b0, ylast, 2'((s + 1) % 4));
      end
    end
    checks++;
    if (c3 !== 18'h20000) begin
      failures++;
      $display("FAIL wrap_comb_steady: got %h, want %h", c3, 18'h20000);
    end

    do_reset();
    for (int s = 0; s < 6; s++) step(1'b1, 12'sd5);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset", 1'b0, 18'd0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 12'sd0);
      chk("continuous_zero", k % 4 == 3, 18'd0, 2'((k + 1) % 4));
    end

`ifdef CIC_INTEG_PHASE_SYNC_EN
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 12'sd0);
    chk("sync_pre", 1'b0, 18'd0, 2'd3);
    sync = 1'b1;
    step(1'b1, 12'sd0);
    sync = 1'b0;
    chk("sync_edge", 1'b0, 18'd0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 12'sd0);
      chk("sync_after", k == 3, 18'd0, 2'((k + 1) % 4));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
